// File: rtl/reg_file_dump.sv
// Sequential register-file dumper: walks [lo_reg..hi_reg] through one read port
// and streams (address, data) snapshots over a valid/ready handshake.
module reg_file_dump #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] lo_reg,
  input  logic [ADDR_WIDTH-1:0] hi_reg,
  output logic [ADDR_WIDTH-1:0] rd_reg,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // out_addr/out_data stay frozen while out_valid is high and out_ready is low.

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] rd_reg_q, rd_reg_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  range_err_q, range_err_d;
  logic                  start_req;
  logic                  hs;
  logic                  last_word;

  assign start_req = start && !abort;
  assign hs        = out_valid_q && out_ready;
  assign last_word = (cur_q == hi_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      rd_reg_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      rd_reg_q    <= rd_reg_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      range_err_q <= range_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_req && (lo_reg <= hi_reg)) state_d = FETCH;
      FETCH: state_d = abort ? IDLE : SEND;
      SEND: begin
        if (abort)   state_d = IDLE;
        else if (hs) state_d = last_word ? FIN : FETCH;
      end
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_reg is loaded on entry to FETCH so the read port already points at cur
  // for the whole FETCH cycle and holds its value otherwise.
  always_comb begin
    cur_d       = cur_q;
    hi_d        = hi_q;
    rd_reg_d    = rd_reg_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    range_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          if (lo_reg <= hi_reg) begin
            cur_d    = lo_reg;
            hi_d     = hi_reg;
            rd_reg_d = lo_reg;
          end else begin
            range_err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort) begin
          out_valid_d = 1'b0;
        end else begin
          out_data_d  = rd_data;
          out_addr_d  = cur_q;
          out_valid_d = 1'b1;
        end
      end
      SEND: begin
        if (abort) begin
          out_valid_d = 1'b0;
        end else if (hs) begin
          out_valid_d = 1'b0;
          if (!last_word) begin
            cur_d    = cur_q + 1'b1;
            rd_reg_d = cur_q + 1'b1;
          end
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_comb begin
    busy      = (state_q == FETCH) || (state_q == SEND);
    done      = (state_q == FIN) && !abort;
    rd_reg    = rd_reg_q;
    out_addr  = out_addr_q;
    out_data  = out_data_q;
    out_valid = out_valid_q;
    range_err = range_err_q;
  end

endmodule

// File: tb/tb_reg_file_dump.sv
// Scoreboard bench for reg_file_dump: a behavioural register file feeds rd_data,
// expected (addr,data) pairs are queued at start and popped on each handshake.
module tb_reg_file_dump;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] lo_reg = '0;
  logic [AW-1:0] hi_reg = '0;
  logic [AW-1:0] rd_reg;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          range_err;

  logic [DW-1:0]    regs [32];
  logic [AW+DW-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int rerr_cnt = 0;
  int hs_cnt = 0;
  int last_hs_cyc = 0;
  bit chk_gap = 1'b0;
  bit gap_first = 1'b1;

  reg_file_dump #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_reg(lo_reg), .hi_reg(hi_reg), .rd_reg(rd_reg), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .range_err(range_err)
  );

  assign rd_data = regs[rd_reg];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Monitor: handshakes cancelled by a coincident abort are not deliveries.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready && !abort) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("unexpected_word", {27'd0, out_addr, out_data}, 64'd0);
        else check("word", {27'd0, out_addr, out_data}, {27'd0, exp_q.pop_front()});
        if (chk_gap && !gap_first) check("word_gap", 64'(cyc - last_hs_cyc), 64'd2);
        gap_first   = 1'b0;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (range_err) rerr_cnt++;
    end
  end

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back({AW'(i), regs[i]});
  endtask

  task automatic start_dump(input int lo, input int hi);
    @(posedge clk); #1;
    start = 1'b1; lo_reg = AW'(lo); hi_reg = AW'(hi);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) check("done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, h0, r0;
    for (int i = 0; i < 32; i++) regs[i] = DW'(i * 3);

    // Reset values
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rerr", 64'(range_err), 64'd0);
    check("rst_rd_reg", 64'(rd_reg), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Reset in the middle of a stalled SEND of reg 4
    out_ready = 1'b0;
    start_dump(4, 10);
    idle_cycles(2);
    check("pre_rst_addr", 64'(out_addr), 64'd4);
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    out_ready = 1'b1;
    d0 = done_cnt;
    push_range(0, 0);
    start_dump(0, 0);
    check("lat_fetch_busy", 64'(busy), 64'd1);
    check("lat_fetch_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_send_valid", 64'(out_valid), 64'd1);
    check("lat_send_addr", 64'(out_addr), 64'd0);
    wait_done(10);
    check("single0_done", 64'(done_cnt - d0), 64'd1);

    // Full dump with ready tied high
    chk_gap = 1'b1; gap_first = 1'b1;
    d0 = done_cnt; h0 = hs_cnt;
    push_range(0, 31);
    start_dump(0, 31);
    wait_done(100);
    chk_gap = 1'b0;
    check("full_words", 64'(hs_cnt - h0), 64'd32);
    check("full_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("full_done_lag", 64'(done_cyc - last_hs_cyc), 64'd1);
    check("full_busy_after", 64'(busy), 64'd0);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure with a register-file write during the stall
    out_ready = 1'b0;
    d0 = done_cnt;
    push_range(5, 7);
    start_dump(5, 7);
    @(posedge clk); #1;
    regs[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_addr", 64'(out_addr), 64'd5);
      check("stall_data", 64'(out_data), 64'd15);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_done(20);
    check("bp_done_cnt", 64'(done_cnt - d0), 64'd1);
    regs[5] = DW'(15);

    // Inverted range
    d0 = done_cnt; h0 = hs_cnt; r0 = rerr_cnt;
    start_dump(9, 3);
    check("rerr_pulse", 64'(range_err), 64'd1);
    check("rerr_busy", 64'(busy), 64'd0);
    idle_cycles(4);
    check("rerr_count", 64'(rerr_cnt - r0), 64'd1);
    check("rerr_no_word", 64'(hs_cnt - h0), 64'd0);
    check("rerr_no_done", 64'(done_cnt - d0), 64'd0);

    // Single word at the top index, no wrap
    d0 = done_cnt; h0 = hs_cnt;
    push_range(31, 31);
    start_dump(31, 31);
    wait_done(10);
    idle_cycles(3);
    check("top_words", 64'(hs_cnt - h0), 64'd1);
    check("top_done", 64'(done_cnt - d0), 64'd1);

    // Abort in IDLE blocks a coincident start
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1; lo_reg = 0; hi_reg = 3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("idle_abort_busy", 64'(busy), 64'd0);

    // Abort on the word-2 handshake; a start while busy is ignored
    d0 = done_cnt; h0 = hs_cnt;
    push_range(0, 1);
    start_dump(0, 10);
    start = 1'b1; lo_reg = 20; hi_reg = 25;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      while (!(out_valid && out_addr == 2) && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 20) check("abort_reach_timeout", 64'd0, 64'd1);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    idle_cycles(5);
    check("abort_words", 64'(hs_cnt - h0), 64'd2);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_dump.md
Name: reg_file_dump

Overview:
- Sequential reader for the CPU register file. On a start pulse it walks a contiguous register range [lo..hi] through one register-file read port.
- Each word is streamed out as an (address, data) pair over a valid/ready handshake.
- Used by the testbench/debug path to dump architectural state after a program run, without touching the CPU datapath's own read ports.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, register word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- abort  input  1  synchronous cancel of a running dump
- lo_reg  input  ADDR_WIDTH  first register index, latched on accepted start
- hi_reg  input  ADDR_WIDTH  last register index inclusive, latched on accepted start
- rd_reg  output  ADDR_WIDTH  read address driven to the register file read port
- rd_data  input  DATA_WIDTH  combinational read data returned by the register file
- out_valid  output  1  out_addr/out_data hold a word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge
- out_addr  output  ADDR_WIDTH  index of the word being presented
- out_data  output  DATA_WIDTH  snapshot of that register
- busy  output  1  high in FETCH and SEND
- done  output  1  one-cycle pulse after the last word is accepted
- range_err  output  1  one-cycle pulse when a start has lo_reg > hi_reg

Behaviour:
- Reset: async on rst=1. State=IDLE. rd_reg, out_addr, cur, hi_latch=0; out_data=0; out_valid, busy, done, range_err=0. Reset mid-dump discards everything; no done pulse.
- States: IDLE, FETCH, SEND, FIN.
- IDLE, start=1 and lo_reg<=hi_reg: latch cur=lo_reg, hi_latch=hi_reg; go to FETCH.
- IDLE, start=1 and lo_reg>hi_reg: stay IDLE; range_err=1 for exactly the next cycle; no words; no done.
- FETCH (1 cycle):
  - rd_reg=cur.
  - At the edge, capture out_data<=rd_data and out_addr<=cur; set out_valid=1; go to SEND.
- SEND:
  - out_valid=1; out_addr and out_data are held stable while out_ready=0 (no change, even if the register file is written meanwhile).
  - On handshake with cur==hi_latch: out_valid<=0; go to FIN.
  - On handshake otherwise: cur<=cur+1; out_valid<=0; go to FETCH.
- FIN: done=1 for this single cycle; go to IDLE.
- Throughput: max one word per 2 cycles. Latency from start edge to first out_valid is 2 rising edges.
- Index arithmetic: cur is ADDR_WIDTH bits unsigned. The cur==hi_latch check precedes increment, so hi_reg=31 never wraps to 0.
- Single-register dump (lo_reg==hi_reg): exactly one word, then done.
- start while busy (FETCH/SEND/FIN): ignored; lo_reg/hi_reg changes have no effect.
- abort=1 in FETCH/SEND/FIN: next state IDLE; out_valid<=0; no done. abort has priority over a coincident handshake; that word counts as not delivered. abort in IDLE: no effect, and it blocks a coincident start.
- Coherency: each word is a snapshot at its FETCH edge. A register-file write in the same cycle as FETCH shows the pre-write value, because the register file write is edge-committed.
- rd_reg holds its last value outside FETCH; the register file read is side-effect free.
- busy is derived purely from state (no extra cycle).

Test Plan:
- Reset mid-dump: during SEND of reg 4, assert rst asynchronously (mid-cycle) -> out_valid, busy, done drop immediately. After release, start lo=0 hi=0 -> one word, addr 0.
- Full dump, ready tied 1: registers preloaded with value=index*3; start lo=0 hi=31 -> 32 words, addr 0..31, data 0,3,...,93, in order, one every 2 cycles. done pulses once, 1 cycle after the addr-31 handshake. busy low afterwards.
- Backpressure: lo=5 hi=7, out_ready low for 4 cycles on the first word; write reg5=0xDEAD_BEEF during the stall -> out_addr=5 and out_data stay at the pre-write value until accepted. Then words 6 and 7 follow, then done.
- Range error and edges: start lo=9 hi=3 -> range_err 1-cycle pulse, no out_valid, no done. start lo=31 hi=31 -> single word addr 31, no wrap to 0.
- Abort and ignored start: lo=0 hi=10, assert abort on the word-2 handshake cycle -> IDLE, word 2 not counted, no done. A start pulse during busy with lo=20 hi=25 -> ignored; the dump continues with the original range.
